// File: rtl/multi_sprite_renderer.sv
// Multi-object rectangle renderer: erases last frame's sprites, then draws
// this frame's sprites as a clipped pixel stream for the VGA adapter.
module multi_sprite_renderer #(
   parameter int NUM_OBJ = 4,
   parameter int X_W = 8,
   parameter int Y_W = 7,
   parameter int DIM_W = 5,
   parameter int C_W = 3,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter logic [C_W-1:0] BG_COLOUR = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     frame_start,
   input  logic [NUM_OBJ*X_W-1:0]   obj_x,
   input  logic [NUM_OBJ*Y_W-1:0]   obj_y,
   input  logic [NUM_OBJ*DIM_W-1:0] obj_w,
   input  logic [NUM_OBJ*DIM_W-1:0] obj_h,
   input  logic [NUM_OBJ*C_W-1:0]   obj_c,
   input  logic [NUM_OBJ-1:0]       obj_en,
   output logic [X_W-1:0]           pix_x,
   output logic [Y_W-1:0]           pix_y,
   output logic [C_W-1:0]           pix_c,
   output logic                     plot,
   output logic                     busy,
   output logic                     frame_done
);

   localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_OBJ - 1);
   localparam logic [X_W:0] SCR_W = (X_W + 1)'(SCREEN_W);
   localparam logic [Y_W:0] SCR_H = (Y_W + 1)'(SCREEN_H);
   localparam logic [DIM_W-1:0] D_ONE = DIM_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ERASE_SEL,
      ERASE_PIX,
      DRAW_SEL,
      DRAW_PIX,
      DONE
   } state_t;

   state_t state, nxt_state, adv_state;

   logic [IDX_W-1:0] idx, nxt_idx, adv_idx;
   logic [DIM_W-1:0] ox, oy, nxt_ox, nxt_oy;

   logic [X_W-1:0]   cur_x  [NUM_OBJ];
   logic [Y_W-1:0]   cur_y  [NUM_OBJ];
   logic [DIM_W-1:0] cur_w  [NUM_OBJ];
   logic [DIM_W-1:0] cur_h  [NUM_OBJ];
   logic [C_W-1:0]   cur_c  [NUM_OBJ];
   logic [NUM_OBJ-1:0] cur_en;

   logic [X_W-1:0]   prev_x [NUM_OBJ];
   logic [Y_W-1:0]   prev_y [NUM_OBJ];
   logic [DIM_W-1:0] prev_w [NUM_OBJ];
   logic [DIM_W-1:0] prev_h [NUM_OBJ];
   logic [C_W-1:0]   prev_c [NUM_OBJ];
   logic [NUM_OBJ-1:0] prev_en;

   logic             erase_pass;
   logic [X_W-1:0]   s_x;
   logic [Y_W-1:0]   s_y;
   logic [DIM_W-1:0] s_w;
   logic [DIM_W-1:0] s_h;
   logic [C_W-1:0]   s_c;
   logic             s_en;
   logic             s_ok;
   logic             last_px;
   logic             last_col;
   logic             nxt_pix;
   logic [X_W:0]     sum_x;
   logic [Y_W:0]     sum_y;

   assign busy       = (state != IDLE);
   assign frame_done = (state == DONE);
   assign erase_pass = (state == ERASE_SEL) || (state == ERASE_PIX);

   // The object under the index, taken from the snapshot of the active pass
   always_comb begin
      s_x  = erase_pass ? prev_x[idx]  : cur_x[idx];
      s_y  = erase_pass ? prev_y[idx]  : cur_y[idx];
      s_w  = erase_pass ? prev_w[idx]  : cur_w[idx];
      s_h  = erase_pass ? prev_h[idx]  : cur_h[idx];
      s_c  = erase_pass ? prev_c[idx]  : cur_c[idx];
      s_en = erase_pass ? prev_en[idx] : cur_en[idx];
   end

   assign s_ok     = s_en && (s_w != '0) && (s_h != '0);
   assign last_col = (ox == s_w - D_ONE);
   assign last_px  = last_col && (oy == s_h - D_ONE);

   always_comb begin
      adv_idx   = idx + IDX_W'(1);
      adv_state = erase_pass ? ERASE_SEL : DRAW_SEL;
      if (idx == LAST) begin
         adv_idx   = '0;
         adv_state = erase_pass ? DRAW_SEL : DONE;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_idx   = idx;
      nxt_ox    = ox;
      nxt_oy    = oy;
      unique case (state)
         IDLE: begin
            if (frame_start) nxt_state = LOAD;
         end
         LOAD: begin
            nxt_idx   = '0;
            nxt_state = ERASE_SEL;
         end
         ERASE_SEL, DRAW_SEL: begin
            if (s_ok) begin
               nxt_ox    = '0;
               nxt_oy    = '0;
               nxt_state = erase_pass ? ERASE_PIX : DRAW_PIX;
            end else begin
               nxt_idx   = adv_idx;
               nxt_state = adv_state;
            end
         end
         ERASE_PIX, DRAW_PIX: begin
            if (last_px) begin
               nxt_idx   = adv_idx;
               nxt_state = adv_state;
            end else if (last_col) begin
               nxt_ox = '0;
               nxt_oy = oy + D_ONE;
            end else begin
               nxt_ox = ox + D_ONE;
            end
         end
         DONE: begin
            nxt_state = IDLE;
         end
         default: begin
            nxt_state = IDLE;
         end
      endcase
   end

   // Pixel registers are loaded with the offset the FSM is about to visit,
   // so plot lines up with the PIX cycle that owns it.
   assign nxt_pix = (nxt_state == ERASE_PIX) || (nxt_state == DRAW_PIX);
   assign sum_x   = {1'b0, s_x} + (X_W + 1)'(nxt_ox);
   assign sum_y   = {1'b0, s_y} + (Y_W + 1)'(nxt_oy);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         idx   <= '0;
         ox    <= '0;
         oy    <= '0;
      end else begin
         state <= nxt_state;
         idx   <= nxt_idx;
         ox    <= nxt_ox;
         oy    <= nxt_oy;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pix_x <= '0;
         pix_y <= '0;
         pix_c <= '0;
         plot  <= 1'b0;
      end else if (nxt_pix) begin
         pix_x <= sum_x[X_W-1:0];
         pix_y <= sum_y[Y_W-1:0];
         pix_c <= erase_pass ? BG_COLOUR : s_c;
         plot  <= (sum_x < SCR_W) && (sum_y < SCR_H);
      end else begin
         plot  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_en <= '0;
         for (int i = 0; i < NUM_OBJ; i++) begin
            cur_x[i] <= '0;
            cur_y[i] <= '0;
            cur_w[i] <= '0;
            cur_h[i] <= '0;
            cur_c[i] <= '0;
         end
      end else if (state == LOAD) begin
         cur_en <= obj_en;
         for (int i = 0; i < NUM_OBJ; i++) begin
            cur_x[i] <= obj_x[i*X_W +: X_W];
            cur_y[i] <= obj_y[i*Y_W +: Y_W];
            cur_w[i] <= obj_w[i*DIM_W +: DIM_W];
            cur_h[i] <= obj_h[i*DIM_W +: DIM_W];
            cur_c[i] <= obj_c[i*C_W +: C_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_en <= '0;
         for (int i = 0; i < NUM_OBJ; i++) begin
            prev_x[i] <= '0;
            prev_y[i] <= '0;
            prev_w[i] <= '0;
            prev_h[i] <= '0;
            prev_c[i] <= '0;
         end
      end else if (state == DONE) begin
         prev_en <= cur_en;
         for (int i = 0; i < NUM_OBJ; i++) begin
            prev_x[i] <= cur_x[i];
            prev_y[i] <= cur_y[i];
            prev_w[i] <= cur_w[i];
            prev_h[i] <= cur_h[i];
            prev_c[i] <= cur_c[i];
         end
      end
   end

endmodule

// File: tb/tb_multi_sprite_renderer.sv
// Directed bench for multi_sprite_renderer with a rectangle-list model.
// Expected pixel streams and frame lengths come from plain loops.
module tb_multi_sprite_renderer;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           frame_start = 1'b0;
   logic [N*8-1:0] obj_x = '0;
   logic [N*7-1:0] obj_y = '0;
   logic [N*5-1:0] obj_w = '0;
   logic [N*5-1:0] obj_h = '0;
   logic [N*3-1:0] obj_c = '0;
   logic [N-1:0]   obj_en = '0;
   logic [7:0]     pix_x;
   logic [6:0]     pix_y;
   logic [2:0]     pix_c;
   logic           plot;
   logic           busy;
   logic           frame_done;

   always #5 clk = ~clk;

   multi_sprite_renderer dut (
      .clk        (clk),
      .reset      (reset),
      .frame_start(frame_start),
      .obj_x      (obj_x),
      .obj_y      (obj_y),
      .obj_w      (obj_w),
      .obj_h      (obj_h),
      .obj_c      (obj_c),
      .obj_en     (obj_en),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_c      (pix_c),
      .plot       (plot),
      .busy       (busy),
      .frame_done (frame_done)
   );

   typedef struct {
      int x;
      int y;
      int c;
   } px_t;

   px_t exp_q[$];
   px_t log_q[$];

   int mx[N], my[N], mw[N], mh[N], mc[N];
   bit men[N];
   int qx[N], qy[N], qw[N], qh[N];
   bit qen[N];

   int exp_len, bcnt, done_cnt;
   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   // One rectangle list per pass; every pixel costs a cycle, only visible
   // ones appear in the stream.
   task automatic build();
      int cyc;
      cyc = 0;
      exp_q.delete();
      for (int i = 0; i < N; i++)
         if (qen[i] && qw[i] > 0 && qh[i] > 0)
            for (int y = 0; y < qh[i]; y++)
               for (int x = 0; x < qw[i]; x++) begin
                  cyc++;
                  if (qx[i] + x < 160 && qy[i] + y < 120)
                     exp_q.push_back('{qx[i] + x, qy[i] + y, 0});
               end
      for (int i = 0; i < N; i++)
         if (men[i] && mw[i] > 0 && mh[i] > 0)
            for (int y = 0; y < mh[i]; y++)
               for (int x = 0; x < mw[i]; x++) begin
                  cyc++;
                  if (mx[i] + x < 160 && my[i] + y < 120)
                     exp_q.push_back('{mx[i] + x, my[i] + y, mc[i]});
               end
      exp_len = 2 + 2 * N + cyc;
      for (int i = 0; i < N; i++) begin
         qx[i]  = mx[i];
         qy[i]  = my[i];
         qw[i]  = mw[i];
         qh[i]  = mh[i];
         qen[i] = men[i];
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         obj_x[i*8 +: 8] = 8'(mx[i]);
         obj_y[i*7 +: 7] = 7'(my[i]);
         obj_w[i*5 +: 5] = 5'(mw[i]);
         obj_h[i*5 +: 5] = 5'(mh[i]);
         obj_c[i*3 +: 3] = 3'(mc[i]);
         obj_en[i]       = men[i];
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (busy) bcnt++;
         if (frame_done) begin
            done_cnt++;
            chk("done_cycle", bcnt, exp_len);
         end
         if (plot) begin
            log_q.push_back('{int'(pix_x), int'(pix_y), int'(pix_c)});
            if (exp_q.size() == 0) begin
               chk("extra_plot_x", int'(pix_x), -1);
            end else begin
               px_t e;
               e = exp_q.pop_front();
               chk("plot_x", int'(pix_x), e.x);
               chk("plot_y", int'(pix_y), e.y);
               chk("plot_c", int'(pix_c), e.c);
            end
         end
      end
   end

   task automatic run_frame(input int ignore_at, input bit rst_mid);
      bit ended;
      ended = 1'b0;
      drive();
      build();
      bcnt = 0;
      done_cnt = 0;
      log_q.delete();
      chk_en = 1'b1;
      @(posedge clk);
      #1 frame_start = 1'b1;
      @(posedge clk);
      #1 frame_start = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (rst_mid && plot && pix_c != 3'd0) begin
            chk_en = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            chk("rst_plot", int'(plot), 0);
            chk("rst_busy", int'(busy), 0);
            reset = 1'b0;
            for (int i = 0; i < N; i++) qen[i] = 1'b0;
            return;
         end
         frame_start = (k == ignore_at);
         if (!busy) begin
            ended = 1'b1;
            break;
         end
      end
      frame_start = 1'b0;
      chk("frame_ends", int'(ended), 1);
      chk("frame_len", bcnt, exp_len);
      chk("done_pulses", done_cnt, 1);
      chk("missing_plots", exp_q.size(), 0);
      chk_en = 1'b0;
   endtask

   function automatic int count_c(input int c);
      int n;
      n = 0;
      foreach (log_q[i]) if (log_q[i].c == c) n++;
      return n;
   endfunction

   function automatic int count_y(input int y);
      int n;
      n = 0;
      foreach (log_q[i]) if (log_q[i].y == y) n++;
      return n;
   endfunction

   initial begin
      for (int i = 0; i < N; i++) begin
         mx[i] = 0; my[i] = 0; mw[i] = 0; mh[i] = 0; mc[i] = 0; men[i] = 0;
         qx[i] = 0; qy[i] = 0; qw[i] = 0; qh[i] = 0; qen[i] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_pix_x", int'(pix_x), 0);
      chk("rst_pix_y", int'(pix_y), 0);
      chk("rst_pix_c", int'(pix_c), 0);
      chk("rst_plot0", int'(plot), 0);
      chk("rst_busy0", int'(busy), 0);
      chk("rst_done0", int'(frame_done), 0);
      reset = 1'b0;

      mx[0] = 10; my[0] = 20; mw[0] = 2; mh[0] = 3; mc[0] = 4; men[0] = 1;
      run_frame(-1, 1'b0);
      chk("f1_len_lit", bcnt, 16);
      chk("f1_nplots_lit", log_q.size(), 6);
      if (log_q.size() == 6) begin
         chk("f1_p0_x", log_q[0].x, 10);
         chk("f1_p0_y", log_q[0].y, 20);
         chk("f1_p1_x", log_q[1].x, 11);
         chk("f1_p2_y", log_q[2].y, 21);
         chk("f1_p5_x", log_q[5].x, 11);
         chk("f1_p5_y", log_q[5].y, 22);
         chk("f1_p5_c", log_q[5].c, 4);
      end

      mx[0] = 12;
      run_frame(-1, 1'b0);
      chk("f2_len_lit", bcnt, 22);
      chk("f2_nplots_lit", log_q.size(), 12);
      if (log_q.size() == 12) begin
         chk("f2_e0_x", log_q[0].x, 10);
         chk("f2_e0_c", log_q[0].c, 0);
         chk("f2_d0_x", log_q[6].x, 12);
         chk("f2_d0_c", log_q[6].c, 4);
      end

      mx[1] = 158; my[1] = 118; mw[1] = 4; mh[1] = 4; mc[1] = 2; men[1] = 1;
      run_frame(-1, 1'b0);
      chk("f3_len_lit", bcnt, 38);
      chk("f3_clip_plots", count_c(2), 4);

      mx[2] = 254; my[2] = 5; mw[2] = 4; mh[2] = 1; mc[2] = 5; men[2] = 1;
      mx[3] = 30; my[3] = 30; mw[3] = 0; mh[3] = 3; mc[3] = 1; men[3] = 1;
      run_frame(5, 1'b0);
      chk("f4_len_lit", bcnt, 58);
      chk("f4_wrap_plots", count_y(5), 0);
      chk("f4_zero_w", count_c(1), 0);

      repeat (4) @(negedge clk);
      chk("ignored_start", int'(busy), 0);

      run_frame(-1, 1'b1);

      run_frame(-1, 1'b0);
      chk("f6_no_erase", count_c(0), 0);
      chk("f6_len_lit", bcnt, 10 + 6 + 16 + 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multi_sprite_renderer.md
Name: multi_sprite_renderer

Overview:
- Parametrised successor to the fixed four-object display handler and draw pair.
- Renders NUM_OBJ solid rectangles per frame into a pixel stream (pix_x/pix_y/pix_c/plot) for the VGA adapter.
- Each frame runs two passes: an erase pass that paints last frame's rectangles with BG_COLOUR, then a draw pass that paints this frame's rectangles.
- Adds per-object enable, screen clipping, zero-size skip and snapshotting of object inputs at frame start.

Parameters:
NUM_OBJ, 4, number of objects (object 0 = player, rest = enemies)
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
DIM_W, 5, width/height field width
C_W, 3, colour width
SCREEN_W, 160, visible columns; x >= SCREEN_W is clipped
SCREEN_H, 120, visible rows; y >= SCREEN_H is clipped
BG_COLOUR, 0, erase colour

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle request to render a frame
obj_x  in  NUM_OBJ*X_W  object top-left x, object i at [i*X_W +: X_W]
obj_y  in  NUM_OBJ*Y_W  object top-left y
obj_w  in  NUM_OBJ*DIM_W  object width in pixels
obj_h  in  NUM_OBJ*DIM_W  object height in pixels
obj_c  in  NUM_OBJ*C_W  object colour
obj_en  in  NUM_OBJ  object visible this frame
pix_x  out  X_W  pixel x
pix_y  out  Y_W  pixel y
pix_c  out  C_W  pixel colour
plot  out  1  pixel valid / write enable
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE.
  - pix_x, pix_y, pix_c, plot, busy and frame_done are all 0.
  - All prev-frame snapshot registers are cleared, including prev_en = 0, so the first frame after reset erases nothing.
  - Reset asserted mid-frame aborts the frame immediately. No further plot pulses occur from the next cycle.
- FSM states: IDLE, LOAD, ERASE_SEL, ERASE_PIX, DRAW_SEL, DRAW_PIX, DONE.
- IDLE:
  - frame_start = 1 moves the FSM to LOAD.
  - frame_start is ignored in every other state; it is neither queued nor counted.
- LOAD (1 cycle):
  - Captures all obj_* inputs into the cur snapshot.
  - Sets obj index = 0.
- busy = 1 in every state except IDLE.
- ERASE_SEL (1 cycle per object):
  - Uses the prev snapshot of object idx.
  - If prev_en[idx] = 1, w != 0 and h != 0: load the offset counters (ox = 0, oy = 0) and go to ERASE_PIX.
  - Otherwise advance idx. After idx = NUM_OBJ-1, reset idx to 0 and go to DRAW_SEL.
- ERASE_PIX / DRAW_PIX (1 cycle per pixel):
  - Raster order: ox is the inner loop (0..w-1), oy the outer loop (0..h-1).
  - The cycle after offset (w-1, h-1), return to the matching SEL state with idx+1, or leave the pass if idx was the last object.
- DRAW_SEL / DRAW_PIX:
  - Same sequencing as the erase pass, using the cur snapshot and cur_en.
  - After the last object, go to DONE.
- Pixel output:
  - Registered; one pixel per PIX cycle.
  - pix_x = x + ox and pix_y = y + oy, computed at X_W+1 / Y_W+1 bits.
  - pix_c = BG_COLOUR in the erase pass, the object colour in the draw pass.
  - plot = 1 only if the unclipped sum < SCREEN_W (x) and < SCREEN_H (y). Otherwise plot = 0, but the cycle is still consumed.
  - A wrapped address (e.g. x = 254 + 3) must never plot.
- DONE (1 cycle):
  - frame_done = 1.
  - prev snapshot <= cur snapshot.
  - Next state is IDLE; busy drops in the IDLE cycle.
- Latency: frame length = 1 (LOAD) + 2*NUM_OBJ (SEL) + sum of erased w*h + sum of drawn w*h + 1 (DONE).
- Overlap: later objects overwrite earlier ones (higher index on top). The erase pass always runs completely before the draw pass starts.
- Outside PIX states, plot = 0 and pix_* hold their last value.

Test Plan:
- Reset, then frame_start with obj0 = (10,20), w=2, h=3, c=3'b100, en=1, others en=0 -> busy for 16 cycles. 6 plots in order (10,20) (11,20) (10,21) (11,21) (10,22) (11,22), all c=4, no erase plots. frame_done pulses in the 16th busy cycle.
- Second frame with obj0 moved to (12,20) -> first 6 plots at the old pixels with c=0, then 6 plots at (12..13, 20..22) with c=4. Frame is 22 cycles.
- obj1 = (158,118), w=4, h=4, en=1 -> only (158,118) (159,118) (158,119) (159,119) plot. 16 pixel cycles are consumed.
- obj2 = (254,5), w=4, h=1 -> plots at 254? No: x >= 160, so 0 plots. No plot at x = 0 or 1 (wrap check). 4 pixel cycles consumed.
- obj3 enabled with w=0 -> only its SEL cycle is spent and no plot occurs, in both draw and the next frame's erase. frame_start pulsed while busy=1 -> ignored; exactly one frame_done.
- Reset asserted during DRAW_PIX -> plot = 0 and busy = 0 from the next cycle. The next frame performs no erase plots.
